// File: rtl/kat_dac_pkg.sv
// Shared types and constants for the KAT DAC transmit interface.
// Sample words pack I0..I3 into bits [31:0] and Q0..Q3 into bits [63:32], one byte each.
package kat_dac_pkg;

   localparam int SAMPLE_W = 8;
   localparam int WORD_W   = 64;
   localparam int LANE_W   = 32;

   localparam logic [SAMPLE_W-1:0] MIDSCALE  = 8'h80;
   localparam logic [LANE_W-1:0]   MID_LANES = {4{MIDSCALE}};

   // Byte offsets of each DAC lane inside a 32-bit rise/fall word.
   localparam int DI_D = 0;
   localparam int DI   = 8;
   localparam int DQ_D = 16;
   localparam int DQ   = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESET = 2'd1,
      SYNC  = 2'd2,
      RUN   = 2'd3
   } tx_state_e;

   typedef struct packed {
      logic [LANE_W-1:0] rise;
      logic [LANE_W-1:0] fall;
   } lane_pair_t;

   // Inverse of the ADC demux: even samples on the delayed lane, rise carries samples 0/1.
   function automatic lane_pair_t format_word(input logic [WORD_W-1:0] w, input logic twos);
      logic [SAMPLE_W-1:0] flip;
      lane_pair_t          p;
      flip = {twos, 7'b0};
      p.rise[DI_D +: SAMPLE_W] = w[0  +: SAMPLE_W] ^ flip;
      p.rise[DI   +: SAMPLE_W] = w[8  +: SAMPLE_W] ^ flip;
      p.rise[DQ_D +: SAMPLE_W] = w[32 +: SAMPLE_W] ^ flip;
      p.rise[DQ   +: SAMPLE_W] = w[40 +: SAMPLE_W] ^ flip;
      p.fall[DI_D +: SAMPLE_W] = w[16 +: SAMPLE_W] ^ flip;
      p.fall[DI   +: SAMPLE_W] = w[24 +: SAMPLE_W] ^ flip;
      p.fall[DQ_D +: SAMPLE_W] = w[48 +: SAMPLE_W] ^ flip;
      p.fall[DQ   +: SAMPLE_W] = w[56 +: SAMPLE_W] ^ flip;
      return p;
   endfunction

   // Ramp word: I = base+0..3, Q = ~I, sent without offset-binary conversion.
   function automatic lane_pair_t ramp_lanes(input logic [SAMPLE_W-1:0] base);
      logic [WORD_W-1:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w[k*SAMPLE_W +: SAMPLE_W]      = base + SAMPLE_W'(k);
         w[32 + k*SAMPLE_W +: SAMPLE_W] = ~(base + SAMPLE_W'(k));
      end
      return format_word(w, 1'b0);
   endfunction

endpackage

// File: rtl/kat_dac_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; rd_data is the current head.
module kat_dac_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/kat_dac_tx_interface.sv
// KAT DAC transmit interface: FIFO-buffered sample words, DAC reset/sync bring-up, registered ODDR lanes.
// Optional ramp test pattern (adds port test_mode) when KAT_DAC_TEST_PATTERN_EN is defined.
module kat_dac_tx_interface
   import kat_dac_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int RST_CYCLES  = 16,
   parameter int SYNC_CYCLES = 32,
   parameter int TWOS_COMP   = 1
) (
   input  logic                ctrl_clk_in,
   input  logic                ctrl_reset_n,
   input  logic                enable,
`ifdef KAT_DAC_TEST_PATTERN_EN
   input  logic                test_mode,
`endif
   input  logic [SAMPLE_W-1:0] user_datai0,
   input  logic [SAMPLE_W-1:0] user_datai1,
   input  logic [SAMPLE_W-1:0] user_datai2,
   input  logic [SAMPLE_W-1:0] user_datai3,
   input  logic [SAMPLE_W-1:0] user_dataq0,
   input  logic [SAMPLE_W-1:0] user_dataq1,
   input  logic [SAMPLE_W-1:0] user_dataq2,
   input  logic [SAMPLE_W-1:0] user_dataq3,
   input  logic                user_data_valid,
   output logic                user_data_ready,
   output logic                dac_rst,
   output logic                dac_sync,
   output logic [LANE_W-1:0]   dac_data_rise,
   output logic [LANE_W-1:0]   dac_data_fall,
   output logic [1:0]          tx_state,
   output logic [15:0]         underflow_count
);

   localparam int PHASE_MAX = (RST_CYCLES > SYNC_CYCLES) ? RST_CYCLES : SYNC_CYCLES;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

   tx_state_e           state_q;
   tx_state_e           state_d;
   logic [PHASE_W-1:0]  phase_q;
   logic                dac_rst_q;
   logic                dac_sync_q;
   lane_pair_t          lanes_q;
   lane_pair_t          lanes_d;
   logic [15:0]         uf_q;
   logic                uf_inc;

   logic [WORD_W-1:0]   in_word;
   logic [WORD_W-1:0]   fifo_rd_data;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_flush;
   logic                in_run;
   logic                test_active;

`ifdef KAT_DAC_TEST_PATTERN_EN
   logic [SAMPLE_W-1:0] ramp_base_q;
   assign test_active = test_mode;
`else
   assign test_active = 1'b0;
`endif

   assign in_word = {user_dataq3, user_dataq2, user_dataq1, user_dataq0,
                     user_datai3, user_datai2, user_datai1, user_datai0};

   // Gating ready with enable means a word is never accepted on the edge that aborts.
   assign user_data_ready = enable && (state_q == SYNC || state_q == RUN) && !fifo_full;
   assign fifo_push       = user_data_valid && user_data_ready;
   assign in_run          = enable && (state_q == RUN);
   assign fifo_pop        = in_run && !test_active && !fifo_empty;
   assign fifo_flush      = (state_q == IDLE) || !enable;

   kat_dac_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk     (ctrl_clk_in),
      .rst_n   (ctrl_reset_n),
      .flush   (fifo_flush),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (in_word),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = RESET;
            RESET:   if (phase_q == PHASE_W'(RST_CYCLES - 1))  state_d = SYNC;
            SYNC:    if (phase_q == PHASE_W'(SYNC_CYCLES - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      lanes_d.rise = MID_LANES;
      lanes_d.fall = MID_LANES;
      uf_inc       = 1'b0;
      if (in_run) begin
         if (!fifo_empty) lanes_d = format_word(fifo_rd_data, TWOS_COMP != 0);
         else             uf_inc  = 1'b1;
`ifdef KAT_DAC_TEST_PATTERN_EN
         if (test_mode) begin
            lanes_d = ramp_lanes(ramp_base_q);
            uf_inc  = 1'b0;
         end
`endif
      end
   end

   // Strobes are decoded from the next state so they line up with tx_state.
   always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         dac_rst_q  <= 1'b0;
         dac_sync_q <= 1'b0;
         lanes_q    <= '{rise: MID_LANES, fall: MID_LANES};
         uf_q       <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= (state_d != state_q) ? '0 : phase_q + 1'b1;
         dac_rst_q  <= (state_d == RESET);
         dac_sync_q <= (state_d == SYNC);
         lanes_q    <= lanes_d;
         if (uf_inc && uf_q != 16'hFFFF) uf_q <= uf_q + 16'd1;
      end
   end

`ifdef KAT_DAC_TEST_PATTERN_EN
   always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n)   ramp_base_q <= '0;
      else if (!in_run)    ramp_base_q <= '0;
      else                 ramp_base_q <= ramp_base_q + SAMPLE_W'(4);
   end
`endif

   fifo_flags_consistent: assert property (@(posedge ctrl_clk_in) disable iff (!ctrl_reset_n)
      fifo_empty == (fifo_count == '0));

   assign tx_state        = state_q;
   assign dac_rst         = dac_rst_q;
   assign dac_sync        = dac_sync_q;
   assign dac_data_rise   = lanes_q.rise;
   assign dac_data_fall   = lanes_q.fall;
   assign underflow_count = uf_q;

endmodule

// File: doc/kat_dac_tx_interface.md
Name: kat_dac_tx_interface

Overview:
- Transmit-side companion to the KAT ADC capture interface.
- Accepts four I and four Q 8-bit samples per cycle from user logic through a valid/ready handshake and buffers them in a small synchronous FIFO.
- Drives a DAC reset/sync bring-up sequence, then emits registered rise/fall lane words for external ODDR/OBUFDS primitives.
- Lane mapping is the inverse of the ADC demux: sample0→di_d rise, sample1→di rise, sample2→di_d fall, sample3→di fall; Q is mapped the same way.

Parameters:
- FIFO_DEPTH, 8, entries of 64-bit sample words; power of two, ≥4.
- RST_CYCLES, 16, cycles dac_rst is held high in RESET.
- SYNC_CYCLES, 32, cycles dac_sync is held high in SYNC.
- TWOS_COMP, 1, 1: input samples are two's complement, so invert the MSB to get offset binary; 0: pass through unchanged.

Ports:
- ctrl_clk_in  in  1  sole clock; all logic on the rising edge.
- ctrl_reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; high starts bring-up, low returns to IDLE.
- user_datai0..user_datai3  in  8 each  I samples 0..3.
- user_dataq0..user_dataq3  in  8 each  Q samples 0..3.
- user_data_valid  in  1  sample word present.
- user_data_ready  out  1  word accepted when valid && ready.
- dac_rst  out  1  DAC reset, active high.
- dac_sync  out  1  DAC sync.
- dac_data_rise  out  32  {dq, dq_d, di, di_d} rise bytes.
- dac_data_fall  out  32  {dq, dq_d, di, di_d} fall bytes.
- tx_state  out  2  0 IDLE, 1 RESET, 2 SYNC, 3 RUN.
- underflow_count  out  16  cycles in RUN with the FIFO empty; saturating.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - FIFO empty.
  - dac_rst=0, dac_sync=0, user_data_ready=0.
  - Every lane byte=8'h80 (midscale).
  - underflow_count=0.
- IDLE:
  - Outputs are midscale; FIFO is held flushed.
  - enable=1 → RESET next cycle.
- RESET:
  - dac_rst=1 for exactly RST_CYCLES cycles → SYNC.
- SYNC:
  - dac_sync=1 for exactly SYNC_CYCLES cycles → RUN.
  - user_data_ready=!full, so the FIFO can prefill.
  - Outputs stay midscale.
- RUN:
  - user_data_ready=!full.
  - Every cycle the output register loads:
    - FIFO non-empty: pop the head and format it.
    - FIFO empty: load midscale and increment underflow_count, saturating at 16'hFFFF.
- enable=0 in any non-IDLE state → IDLE next edge:
  - FIFO flushed; any partially sent word is dropped.
  - dac_rst and dac_sync are deasserted.
  - underflow_count is held, not cleared; it clears only on ctrl_reset_n.
- Registered outputs: dac_rst, dac_sync, dac_data_rise, dac_data_fall, tx_state.
- Latency: a word accepted at edge k into an empty FIFO in RUN appears on dac_data_* after edge k+1. Order is strict FIFO.
- Full: ready=0, so no push occurs even if a pop happens the same cycle; ready rises the cycle after count drops.
- Simultaneous push and pop when not full: count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap; count is log2(FIFO_DEPTH)+1 bits.
- user_data_valid while ready=0 has no effect.
- Formatting: each byte gets MSB ^= TWOS_COMP.

Optional Feature:
- Macro: KAT_DAC_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1 in RUN, the FIFO is not popped and underflow is not counted; user_data_ready stays !full.
  - Output is a ramp: I samples base+0..base+3, Q samples the bitwise inverse of those.
  - base starts at 0 on RUN entry and increments by 4 mod 256 each cycle.
  - The ramp bypasses TWOS_COMP formatting.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package kat_dac_pkg:
  - tx_state enum {IDLE, RESET, SYNC, RUN}.
  - MIDSCALE=8'h80.
  - Lane slice offsets DI_D=0, DI=8, DQ_D=16, DQ=24.
  - SAMPLE_W=8, WORD_W=64.
- One sub-module, kat_dac_sync_fifo:
  - Parameterised depth/width, single clock, async reset.
  - Synchronous flush input.
  - Outputs: full, empty, count.

Test Plan:
- Bring-up: release reset, enable=1 → dac_rst high exactly 16 cycles, then dac_sync high exactly 32 cycles, then tx_state=3.
- Mapping: in RUN push I={0x00,0x01,0x02,0x03}, Q={0x10,0x11,0x12,0x13} with TWOS_COMP=1 → next cycle dac_data_rise=32'h91_90_81_80, dac_data_fall=32'h93_92_83_82.
- Backpressure: hold valid with the DAC side stalled in SYNC → exactly 8 words accepted, ready=0; RUN then drains all 8 in order with no loss or duplication.
- Underflow: RUN with valid=0 for 10 cycles → lanes all 8'h80, underflow_count=10; force 70000 cycles → saturates at 16'hFFFF.
- Abort: drop enable mid-RESET and mid-RUN with 3 words queued → IDLE next edge, dac_rst=0, FIFO empty, ready=0; re-enable replays the full sequence.
- Async reset asserted mid-RUN without a clock edge → outputs immediately midscale, dac_rst=0, count=0.
